// File: rtl/buf_pkg.sv
// buf_pkg: shared state encoding and default data width for buffer-port arbiters.
package buf_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;
  localparam int DATA_L_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
  end
endmodule

// File: rtl/buf_wr_arbiter.sv
// buf_wr_arbiter: round-robin sharing of one buffer write port with a level we/w_ack handshake.
// Define ARB_TIMEOUT_EN to abandon a stalled handshake after TIMEOUT cycles and flag err.
module buf_wr_arbiter
  import buf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_L  = DATA_L_DEF,
  parameter int IDX_L   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_L-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      buf_we,
  output logic [DATA_L-1:0]         buf_din,
  input  logic                      buf_w_ack,
  input  logic                      buf_full,
  output logic                      err
);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, pick_gnt;
  logic [IDX_L-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx, ptr_nxt;
  logic [DATA_L-1:0] din_q, din_d;
  logic we_q, we_d, err_q, err_d;

  rr_pick #(.N(NUM_REQ), .IW(IDX_L)) u_pick (
    .req_i(req), .ptr_i(ptr_q), .gnt_o(pick_gnt), .idx_o(pick_idx)
  );

  assign ptr_nxt = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo;
  assign tmo = (state_q == ST_WAIT_ACK || state_q == ST_WAIT_REL) && (int'(cnt_q) == TIMEOUT - 1);
  assign cnt_d = (state_d != state_q) ? '0 : (int'(cnt_q) == TIMEOUT) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic tmo;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    done_d = '0;
    ptr_d = ptr_q;
    idx_d = idx_q;
    din_d = din_q;
    we_d = we_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: if (|req && !buf_full) begin
        gnt_d = pick_gnt;
        idx_d = pick_idx;
        din_d = req_data[int'(pick_idx)*DATA_L +: DATA_L];
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        we_d = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: if (buf_w_ack) begin
        we_d = 1'b0;
        state_d = ST_WAIT_REL;
      end
      default: if (!buf_w_ack) begin
        done_d = gnt_q;
        gnt_d = '0;
        ptr_d = ptr_nxt;
        state_d = ST_IDLE;
      end
    endcase
    // A stalled handshake is abandoned but still reported as done to the requester
    if (tmo) begin
      we_d = 1'b0;
      err_d = 1'b1;
      done_d = gnt_q;
      gnt_d = '0;
      ptr_d = ptr_nxt;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      done_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      din_q <= din_d;
      we_q <= we_d;
      err_q <= err_d;
    end

  assign gnt = gnt_q;
  assign done = done_q;
  assign busy = state_q != ST_IDLE;
  assign buf_we = we_q;
  assign buf_din = din_q;
`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_buf_wr_arbiter.sv
// tb_buf_wr_arbiter: table-driven grant-order checks plus full, reset and timeout sequences.
module tb_buf_wr_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] req_data = '0;
  logic buf_w_ack = 1'b0, buf_full = 1'b0;
  logic [3:0] gnt, done;
  logic busy, buf_we, err;
  logic [15:0] buf_din;

  always #5 clk = ~clk;

  buf_wr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .busy(busy), .buf_we(buf_we), .buf_din(buf_din), .buf_w_ack(buf_w_ack),
    .buf_full(buf_full), .err(err)
  );

  int n_chk = 0, n_fail = 0;
  bit ack_en = 1'b1;
  int ack_cnt = 0;
  logic [15:0] mem[$];

  // Buffer model: ack two cycles after we rises, release ack once we drops
  always @(negedge clk) begin
    if (buf_we && !buf_w_ack && ack_en) begin
      ack_cnt++;
      if (ack_cnt == 2) begin
        buf_w_ack = 1'b1;
        mem.push_back(buf_din);
        ack_cnt = 0;
      end
    end else if (!buf_we) begin
      buf_w_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  typedef struct {
    bit rst_b;
    logic [3:0] req;
    logic [63:0] rd;
    logic [3:0] exp_gnt;
    logic [15:0] exp_din;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_gnt();
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt != 0) break;
    end
    if (i == 30) chk("gnt_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done != 0) break;
    end
    if (i == 60) chk("done_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem.delete();
  endtask

  localparam logic [63:0] D4 = 64'h0013_0012_0011_0010;

  initial begin
    v[0] = '{1'b1, 4'b0001, 64'h0000_0000_0000_1234, 4'b0001, 16'h1234};
    v[1] = '{1'b1, 4'b1111, D4, 4'b0001, 16'h0010};
    v[2] = '{1'b0, 4'b1111, D4, 4'b0010, 16'h0011};
    v[3] = '{1'b0, 4'b1111, D4, 4'b0100, 16'h0012};
    v[4] = '{1'b0, 4'b1111, D4, 4'b1000, 16'h0013};
    v[5] = '{1'b0, 4'b1111, D4, 4'b0001, 16'h0010};
    v[6] = '{1'b0, 4'b1111, D4, 4'b0010, 16'h0011};
    v[7] = '{1'b0, 4'b0100, D4, 4'b0100, 16'h0012};
    v[8] = '{1'b0, 4'b0101, D4, 4'b0001, 16'h0010};
    v[9] = '{1'b0, 4'b0101, D4, 4'b0100, 16'h0012};

    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_din", buf_din, 0);
    chk("rst_err", err, 0);

    for (int i = 0; i < 10; i++) begin
      if (v[i].rst_b) do_reset();
      req_data = v[i].rd;
      req = v[i].req;
      wait_gnt();
      chk($sformatf("gnt[%0d]", i), gnt, v[i].exp_gnt);
      chk($sformatf("busy[%0d]", i), busy, 1);
      @(negedge clk);
      chk($sformatf("we[%0d]", i), buf_we, 1);
      chk($sformatf("din[%0d]", i), buf_din, v[i].exp_din);
      wait_done();
      chk($sformatf("done[%0d]", i), done, v[i].exp_gnt);
      chk($sformatf("gnt_clr[%0d]", i), gnt, 0);
      chk($sformatf("mem[%0d]", i), mem[$], v[i].exp_din);
      req = '0;
      @(negedge clk);
      chk($sformatf("done_1cyc[%0d]", i), done, 0);
    end

    buf_full = 1'b1;
    req_data = D4;
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("full_gnt", gnt, 0);
      chk("full_we", buf_we, 0);
    end
    buf_full = 1'b0;
    @(negedge clk);
    chk("full_release_gnt", gnt, 4'b0010);
    wait_done();
    chk("full_release_done", done, 4'b0010);
    req = '0;

    ack_en = 1'b0;
    req = 4'b1000;
    wait_gnt();
    chk("rstmid_gnt", gnt, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_we", buf_we, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_gnt0", gnt, 0);
    chk("rstmid_we0", buf_we, 0);
    chk("rstmid_done0", done, 0);
    chk("rstmid_busy0", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    req = 4'b0100;
    wait_gnt();
    chk("rstmid_fresh_gnt", gnt, 4'b0100);
    wait_done();
    chk("rstmid_fresh_done", done, 4'b0100);
    req = '0;
    chk("err_clear", err, 0);

`ifdef ARB_TIMEOUT_EN
    begin
      int c;
      ack_en = 1'b0;
      req = 4'b0001;
      wait_gnt();
      @(negedge clk);
      chk("tmo_we", buf_we, 1);
      for (c = 0; c < 40; c++) begin
        if (done != 0) break;
        @(negedge clk);
      end
      chk("tmo_cycles", c, 15);
      chk("tmo_done", done, 4'b0001);
      chk("tmo_we0", buf_we, 0);
      chk("tmo_err", err, 1);
      req = '0;
      repeat (5) @(negedge clk);
      chk("tmo_err_sticky", err, 1);
      chk("tmo_idle", busy, 0);
      do_reset();
      chk("tmo_err_rst", err, 0);
      ack_en = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/buf_wr_arbiter.md
Name: buf_wr_arbiter

Overview:
- Shares one write port of a single buffer FIFO among NUM_REQ requesters, using round-robin arbitration.
- Sequences the buffer's level-based write handshake: raise we, wait for w_ack high, drop we, wait for w_ack low.
- Returns a one-cycle done pulse to the winning requester.
- Sits between producer stages (fetch/IO units) and the buffer instance they share.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_L, 16, data width; matches the buffer's DATA_L.
- IDX_L, 2, width of the requester index; must satisfy 2**IDX_L >= NUM_REQ.
- TIMEOUT, 15, ack-wait cycle limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NUM_REQ  per-requester write request; level, held until done.
- req_data  input  NUM_REQ*DATA_L  per-requester data; slice i is bits [i*DATA_L +: DATA_L].
- gnt  output  NUM_REQ  one-hot; high for the whole transaction of the granted requester.
- done  output  NUM_REQ  one-cycle pulse to the granted requester when its write completes.
- busy  output  1  high whenever state != IDLE.
- buf_we  output  1  buffer write enable (level).
- buf_din  output  DATA_L  data presented to the buffer.
- buf_w_ack  input  1  buffer write acknowledge.
- buf_full  input  1  buffer full flag.
- err  output  1  sticky timeout error; stays 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async): state=IDLE; gnt=0, done=0, busy=0, buf_we=0, buf_din=0, err=0; rr pointer=0 (requester 0 has highest priority first).
- Data capture: all state, outputs and buf_din are registered on posedge clk. buf_din is latched at grant and held stable until the transaction ends.
- IDLE:
  - Arbitrate if any req is set and buf_full=0.
  - Winner = first set req scanning ptr, ptr+1, ... mod NUM_REQ.
  - Set gnt[winner], latch req_data slice into buf_din, go to SETUP.
  - If buf_full=1, stay in IDLE and grant nothing.
- SETUP: assert buf_we=1 (data was stable one cycle earlier); go to WAIT_ACK.
- WAIT_ACK: hold buf_we=1 until buf_w_ack=1, then buf_we=0 and go to WAIT_REL.
- WAIT_REL:
  - Wait for buf_w_ack=0.
  - Then pulse done[winner] for 1 cycle, clear gnt, set ptr=winner+1 mod NUM_REQ, go to IDLE.
- Latency: grant to buf_we is 1 cycle. Minimum transaction is 4 cycles from grant to done. Back-to-back grants are separated by 1 IDLE cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- Requester rules:
  - A requester dropping req mid-transaction does not abort the write; done still pulses.
  - A requester must not reassert for a new word before it sees done.
- buf_full rising after grant: the write proceeds. The buffer reports the overflow; the arbiter does not re-check.
- Simultaneous requests: exactly one grant; gnt is never multi-hot.
- Reset mid-transaction: immediate return to IDLE, buf_we=0, no done pulse.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK and WAIT_REL. It clears on every state entry and saturates at TIMEOUT.
  - On reaching TIMEOUT: set err=1 (sticky until rst), drop buf_we, pulse done[winner], advance ptr, go to IDLE.
- Undefined: no counter logic; the arbiter waits on buf_w_ack indefinitely; err is tied to 0.

Decomposition:
- Shared package (buf_pkg): state encoding constants ST_IDLE=0, ST_SETUP=1, ST_WAIT_ACK=2, ST_WAIT_REL=3, and the default DATA_L.
- One sub-module: rr_pick (combinational). Inputs: req vector, ptr. Outputs: one-hot grant and its index. Reusable by a future read-side arbiter.

Test Plan:
- Single request: req=0001, data0=0x1234, buffer model acks 2 cycles after we. Expect gnt=0001; buf_din=0x1234 with buf_we=1 one cycle after grant; done[0] pulses once; buffer holds 0x1234.
- All four request continuously, data i=0x10+i, ptr=0. Expect grant order 0,1,2,3,0,1; buffer contents 0x10,0x11,0x12,0x13,0x10,0x11.
- buf_full=1 with req=0010. Expect no gnt and buf_we=0 for 10 cycles. Drop buf_full: expect grant to requester 1 the next cycle.
- Reset mid-transaction: assert rst during WAIT_ACK. Expect gnt=0, buf_we=0, done=0 immediately; after release, a fresh request gets granted normally.
- Grant-order skipping: req=0101 after requester 2 was last served. Expect requester 0 granted next (wrap), then requester 2.
- ARB_TIMEOUT_EN, TIMEOUT=15, buffer model never acks. Expect buf_we dropped, err=1 and done pulsed 15 cycles after WAIT_ACK entry; err stays 1 until rst.
